vec_issue_sequencer: RTL and testbench
======================================

Name: vec_issue_sequencer

Overview:
- Sits between the scalar processor and the vector datapath. It replaces the ad-hoc ready/ack controller and the instruction queue pairing.
- Buffers incoming instruction, rs1 and rs2 triples in a FIFO and issues them to the datapath one at a time.
- Holds each issued instruction stable until the datapath reports completion, then returns an ack to the scalar core.
- A watchdog flags a datapath that never completes.

Parameters:
- XLEN, 32, width of instruction and scalar operands.
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- TIMEOUT, 1024, maximum EXEC-state cycles before a watchdog abort.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- inst_valid  in  1  scalar core presents a valid instruction.
- instruction  in  XLEN  instruction word.
- rs1_data  in  XLEN  scalar operand 1.
- rs2_data  in  XLEN  scalar operand 2.
- vec_pro_ready  out  1  FIFO can accept an entry this cycle.
- scalar_pro_ready  in  1  scalar core accepts the ack.
- vec_pro_ack  out  1  current instruction retired; held until accepted.
- ack_error  out  1  qualifies vec_pro_ack: retired with datapath error or timeout.
- issue_instruction  out  XLEN  instruction to datapath; registered.
- issue_rs1_data  out  XLEN  rs1 to datapath; registered.
- issue_rs2_data  out  XLEN  rs2 to datapath; registered.
- issue_start  out  1  one-cycle pulse marking a new issue.
- busy  out  1  high in ISSUE, EXEC or ACK.
- inst_done  in  1  datapath completion pulse.
- dp_error  in  1  datapath error; sampled together with inst_done.
- timeout_err  out  1  sticky watchdog flag; cleared only by reset.
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, async):
  - FIFO pointers and count cleared; state is IDLE.
  - Outputs: vec_pro_ready=1, vec_pro_ack=0, ack_error=0, issue_*=0, issue_start=0, busy=0, timeout_err=0, q_count=0.
  - Asserting reset mid-operation discards all queued and in-flight work; no ack is produced for it.
- Enqueue:
  - vec_pro_ready = (count != DEPTH), combinational from registered count.
  - A transfer occurs on every rising edge where inst_valid && vec_pro_ready. Each such cycle writes one entry at wr_ptr, and wr_ptr wraps modulo DEPTH.
  - A valid held high for N ready cycles enqueues N entries; the scalar side must drop valid after its handshake.
  - No enqueue when full; the data is ignored and the scalar core holds it.
- Dequeue: happens only in IDLE with count != 0. That edge loads issue_* from the FIFO head, advances rd_ptr (wraps) and moves to ISSUE.
- Simultaneous push and pop in one cycle: count is unchanged, and both pointers advance.
- State machine:
  - IDLE: busy=0. If count != 0, pop and go to ISSUE.
  - ISSUE: issue_start=1 for exactly this one cycle. The watchdog counter is cleared. Next state is EXEC. If inst_done is high in ISSUE, treat it as in EXEC.
  - EXEC:
    - issue_* stay stable.
    - On inst_done: latch ack_error=dp_error and go to ACK.
    - Otherwise increment the watchdog. At TIMEOUT-1 without inst_done: set timeout_err=1, ack_error=1 and go to ACK.
  - ACK:
    - vec_pro_ack=1 and ack_error stay stable.
    - When scalar_pro_ready=1, the ack completes that edge; vec_pro_ack and ack_error clear and the state goes to IDLE.
    - inst_done arriving in ACK or IDLE is ignored.
- Latency:
  - Handshake edge n to an empty, idle queue: pop at edge n+1, so issue_start is high in the cycle after n+1.
  - inst_done sampled at edge m makes vec_pro_ack high after edge m.
  - Minimum of one IDLE cycle between consecutive instructions.
- Enqueue continues during ISSUE, EXEC and ACK.
- q_count equals the registered count.

Test Plan:
- Reset, then one push of instruction=0x0000_5057, rs1=0x10, rs2=0x3 at edge 1 -> issue_start high after edge 2 with issue_instruction=0x0000_5057. Pulse inst_done 3 cycles later -> vec_pro_ack=1, ack_error=0. scalar_pro_ready=1 one cycle later -> ack drops and state returns to IDLE.
- Push 5 back-to-back entries with DEPTH=4 and a stalled datapath -> entry 1 pops, 4 remain queued. vec_pro_ready=0 after the 5th handshake with q_count=4; a 6th valid is ignored. Complete all -> issue order equals push order (FIFO, pointer wrap checked).
- Push while in ACK with scalar_pro_ready low for 10 cycles -> ack stays stable and q_count increments. Next issue starts one cycle after IDLE entry.
- inst_done with dp_error=1 -> vec_pro_ack=1 and ack_error=1. The next instruction completes with dp_error=0 -> ack_error=0.
- No inst_done with TIMEOUT=16 -> vec_pro_ack with ack_error=1 16 cycles after ISSUE, and timeout_err stays 1 through later instructions until reset.
- Drop reset to 0 during EXEC with 3 queued entries -> all outputs go immediately to reset values and q_count=0. No ack is produced after release.

Source files
------------

// File: rtl/vec_issue_sequencer.sv
// Issue sequencer between the scalar core and the vector datapath: queues
// {instruction, rs1, rs2} requests, issues one at a time and returns an ack.
module vec_issue_sequencer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inst_valid,
  input  logic [XLEN-1:0]            instruction,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            rs2_data,
  output logic                       vec_pro_ready,
  input  logic                       scalar_pro_ready,
  output logic                       vec_pro_ack,
  output logic                       ack_error,
  output logic [XLEN-1:0]            issue_instruction,
  output logic [XLEN-1:0]            issue_rs1_data,
  output logic [XLEN-1:0]            issue_rs2_data,
  output logic                       issue_start,
  output logic                       busy,
  input  logic                       inst_done,
  input  logic                       dp_error,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_ACK} state_t;

  state_t          state, state_nxt;
  req_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [WW-1:0]   wd;
  logic            push, pop, wd_hit;

  assign vec_pro_ready = (count != CW'(DEPTH));
  assign q_count       = count;
  assign push          = inst_valid && vec_pro_ready;
  assign pop           = (state == S_IDLE) && (count != '0);
  assign wd_hit        = (wd == WW'(TIMEOUT - 1));

  // FIFO: power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instruction, rs1_data, rs2_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = inst_done ? S_ACK : S_EXEC;
      S_EXEC:  if (inst_done || wd_hit) state_nxt = S_ACK;
      S_ACK:   if (scalar_pro_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    issue_start = (state == S_ISSUE);
    busy        = (state != S_IDLE);
    vec_pro_ack = (state == S_ACK);
  end

  // Issue registers, watchdog and ack qualifiers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_instruction <= '0;
      issue_rs1_data    <= '0;
      issue_rs2_data    <= '0;
      wd                <= '0;
      ack_error         <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      if (pop) begin
        issue_instruction <= mem[rd_ptr].inst;
        issue_rs1_data    <= mem[rd_ptr].rs1;
        issue_rs2_data    <= mem[rd_ptr].rs2;
      end
      case (state)
        S_ISSUE: begin
          wd <= '0;
          if (inst_done) ack_error <= dp_error;
        end
        S_EXEC: begin
          if (inst_done) begin
            ack_error <= dp_error;
          end else if (wd_hit) begin
            ack_error   <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        S_ACK: if (scalar_pro_ready) ack_error <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Directed + randomized bench for vec_issue_sequencer, checked every cycle
// against a queue-based transaction model.
module tb_vec_issue_sequencer;
  localparam int XLEN = 32, DEPTH = 4, TIMEOUT = 16;

  logic            clk = 1'b0, reset = 1'b0;
  logic            inst_valid = 1'b0, scalar_pro_ready = 1'b0;
  logic            inst_done = 1'b0, dp_error = 1'b0;
  logic [XLEN-1:0] instruction = '0, rs1_data = '0, rs2_data = '0;
  logic            vec_pro_ready, vec_pro_ack, ack_error, issue_start, busy, timeout_err;
  logic [XLEN-1:0] issue_instruction, issue_rs1_data, issue_rs2_data;
  logic [2:0]      q_count;

  vec_issue_sequencer #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .vec_pro_ready(vec_pro_ready),
    .scalar_pro_ready(scalar_pro_ready), .vec_pro_ack(vec_pro_ack), .ack_error(ack_error),
    .issue_instruction(issue_instruction), .issue_rs1_data(issue_rs1_data),
    .issue_rs2_data(issue_rs2_data), .issue_start(issue_start), .busy(busy),
    .inst_done(inst_done), .dp_error(dp_error), .timeout_err(timeout_err), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } ent_t;

  int   vectors = 0, miscompares = 0;
  // model: pending entries, transaction phase (0 idle,1 issue,2 exec,3 ack)
  ent_t mq[$];
  ent_t cur;
  int   ph = 0, ecnt = 0;
  bit   merr = 0, mtmo = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur = '{0, 0, 0};
    ph = 0; ecnt = 0; merr = 0; mtmo = 0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_rdy"},  vec_pro_ready, 1);
    chk({p, "_ack"},  vec_pro_ack, 0);
    chk({p, "_aerr"}, ack_error, 0);
    chk({p, "_inst"}, issue_instruction, 0);
    chk({p, "_rs1"},  issue_rs1_data, 0);
    chk({p, "_rs2"},  issue_rs2_data, 0);
    chk({p, "_st"},   issue_start, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_tmo"},  timeout_err, 0);
    chk({p, "_qc"},   q_count, 0);
  endtask

  // Apply one clock edge with the currently driven inputs, advance the model, compare.
  task automatic step();
    bit rdy, had;
    rdy = (mq.size() < DEPTH);
    had = (mq.size() > 0);
    case (ph)
      0: if (had) begin cur = mq.pop_front(); ph = 1; end
      1: if (inst_done) begin merr = dp_error; ph = 3; end
         else begin ph = 2; ecnt = 0; end
      2: if (inst_done) begin merr = dp_error; ph = 3; end
         else begin
           ecnt++;
           if (ecnt == TIMEOUT) begin merr = 1; mtmo = 1; ph = 3; end
         end
      3: if (scalar_pro_ready) begin merr = 0; ph = 0; end
      default: ph = 0;
    endcase
    if (inst_valid && rdy) mq.push_back('{instruction, rs1_data, rs2_data});
    @(posedge clk);
    @(negedge clk);
    chk("ready",   vec_pro_ready, (mq.size() != DEPTH));
    chk("q_count", q_count, mq.size());
    chk("busy",    busy, (ph != 0));
    chk("start",   issue_start, (ph == 1));
    chk("ack",     vec_pro_ack, (ph == 3));
    chk("ack_err", ack_error, merr);
    chk("tmo",     timeout_err, mtmo);
    chk("i_inst",  issue_instruction, cur.inst);
    chk("i_rs1",   issue_rs1_data, cur.rs1);
    chk("i_rs2",   issue_rs2_data, cur.rs2);
  endtask

  task automatic rand_data();
    instruction = $urandom; rs1_data = $urandom; rs2_data = $urandom;
  endtask

  task automatic push_one();
    inst_valid = 1; rand_data();
    step();
    inst_valid = 0;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !(busy && !vec_pro_ack); i++) step();
    chk("wait_busy", (busy && !vec_pro_ack), 1);
  endtask

  // Complete the in-flight (or next) instruction after d cycles, then accept the ack.
  task automatic finish_one(input int d, input bit e);
    wait_busy();
    repeat (d) step();
    inst_done = 1; dp_error = e;
    step();
    inst_done = 0; dp_error = 0;
    chk("fin_ack", vec_pro_ack, 1);
    chk("fin_aerr", ack_error, e);
    scalar_pro_ready = 1;
    step();
    scalar_pro_ready = 0;
    chk("fin_idle", vec_pro_ack, 0);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1;

    // single instruction, fixed operands
    inst_valid = 1; instruction = 32'h0000_5057; rs1_data = 32'h10; rs2_data = 32'h3;
    step();
    inst_valid = 0;
    step();
    chk("t1_start", issue_start, 1);
    chk("t1_inst", issue_instruction, 32'h0000_5057);
    step(); step();
    inst_done = 1; step(); inst_done = 0;
    chk("t1_ack", vec_pro_ack, 1);
    chk("t1_aerr", ack_error, 0);
    scalar_pro_ready = 1; step(); scalar_pro_ready = 0;
    chk("t1_ackdrop", vec_pro_ack, 0);
    chk("t1_idle", busy, 0);

    // fill past full with a stalled datapath; sixth valid must be ignored
    inst_valid = 1;
    for (int i = 0; i < 6; i++) begin rand_data(); step(); end
    inst_valid = 0;
    chk("t2_qc", q_count, 4);
    chk("t2_rdy", vec_pro_ready, 0);
    for (int i = 0; i < 5; i++) finish_one($urandom_range(0, 3), 0);
    chk("t2_empty", q_count, 0);

    // enqueue while ack is held off
    push_one();
    wait_busy();
    inst_done = 1; step(); inst_done = 0;
    for (int i = 0; i < 10; i++) begin
      inst_valid = (i < 3); rand_data();
      step();
      chk("t3_ack_hold", vec_pro_ack, 1);
    end
    inst_valid = 0;
    chk("t3_qc", q_count, 3);
    scalar_pro_ready = 1; step(); scalar_pro_ready = 0;
    chk("t3_idle", busy, 0);
    step();
    chk("t3_next_start", issue_start, 1);
    for (int i = 0; i < 3; i++) finish_one($urandom_range(0, 2), 0);

    // datapath error then clean completion
    push_one(); push_one();
    finish_one(1, 1);
    finish_one(2, 0);

    // watchdog abort
    push_one();
    for (int i = 0; i < 10 && !issue_start; i++) step();
    chk("t5_issue_seen", issue_start, 1);
    n = 0;
    while (!vec_pro_ack && n < 40) begin step(); n++; end
    chk("t5_latency", n, TIMEOUT + 1);
    chk("t5_aerr", ack_error, 1);
    chk("t5_tmo", timeout_err, 1);
    scalar_pro_ready = 1; step(); scalar_pro_ready = 0;
    push_one();
    finish_one(1, 0);
    chk("t5_tmo_sticky", timeout_err, 1);

    // asynchronous reset during EXEC with queued work
    inst_valid = 1;
    for (int i = 0; i < 4; i++) begin rand_data(); step(); end
    inst_valid = 0;
    chk("t6_qc", q_count, 3);
    chk("t6_busy", busy, 1);
    #2 reset = 0;
    #1 chk_reset_vals("t6");
    model_reset();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t6_no_ack", vec_pro_ack, 0);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      inst_valid       = ($urandom_range(0, 1) == 1);
      rand_data();
      inst_done        = ($urandom_range(0, 3) == 0);
      dp_error         = ($urandom_range(0, 1) == 1);
      scalar_pro_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
